// File: rtl/neuron_mac_engine.sv
// Multi-channel multiply-accumulate neuron: per-beat dot product, saturating
// frame accumulation, bias add and sign decision (1 = cat).
module neuron_mac_engine #(
    parameter int CHANNELS     = 3,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 5,
    parameter int BIAS_WIDTH   = 16,
    parameter int ACC_WIDTH    = 40,
    parameter int COUNT_WIDTH  = 12
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             start,
    input  logic [COUNT_WIDTH-1:0]           beats,
    input  logic [BIAS_WIDTH-1:0]            bias,
    input  logic [CHANNELS*PIXEL_WIDTH-1:0]  x,
    input  logic [CHANNELS*WEIGHT_WIDTH-1:0] w,
    input  logic                             x_valid,
    output logic                             x_ready,
    output logic                             busy,
    output logic                             result_valid,
    output logic                             result,
    output logic [ACC_WIDTH-1:0]             acc_val,
    output logic                             overflow
);

    localparam int PSUM_W = PIXEL_WIDTH + WEIGHT_WIDTH + 1 + $clog2(CHANNELS);
    localparam int SUM_W  = ACC_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, DONE} state_t;

    state_t                         state;
    state_t                         state_next;
    logic [COUNT_WIDTH-1:0]         beats_q;
    logic [COUNT_WIDTH-1:0]         count;
    logic signed [BIAS_WIDTH-1:0]   bias_q;
    logic signed [PSUM_W-1:0]       psum_q;
    logic signed [PSUM_W-1:0]       lane_sum;
    logic                           pipe_valid;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [SUM_W-1:0]        addend;
    logic signed [SUM_W-1:0]        raw_sum;
    logic signed [ACC_WIDTH-1:0]    sat_sum;
    logic                           sat_hit;
    logic                           add_en;
    logic                           accept;
    logic                           last_beat;
    logic                           frame_start;

    assign frame_start = (state == IDLE) && start && !clear;
    assign last_beat   = (count == beats_q - COUNT_WIDTH'(1));
    assign accept      = x_ready && x_valid;
    assign acc_val     = acc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // clear overrides every transition; x_ready drops in the same cycle so no beat slips in
    always_comb begin
        state_next   = state;
        x_ready      = 1'b0;
        busy         = (state != IDLE);
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (beats == '0) ? BIAS : ACCUM;
                end
            end
            ACCUM: begin
                x_ready = 1'b1;
                if (x_valid && last_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:   state_next = BIAS;
            BIAS:    state_next = DONE;
            DONE: begin
                result_valid = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
            x_ready    = 1'b0;
        end
    end

    // Stage 1: full-width dot product of one beat, pixels treated as unsigned
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lane_sum = lane_sum
                + PSUM_W'($signed({1'b0, x[i*PIXEL_WIDTH +: PIXEL_WIDTH]}))
                * PSUM_W'($signed(w[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
        end
    end

    // One shared saturating adder: bias in BIAS, otherwise the pipelined partial sum
    always_comb begin
        add_en  = pipe_valid || (state == BIAS);
        addend  = (state == BIAS) ? SUM_W'(bias_q) : SUM_W'(psum_q);
        raw_sum = SUM_W'(acc) + addend;
        sat_hit = (raw_sum[ACC_WIDTH] != raw_sum[ACC_WIDTH-1]);
        if (!sat_hit) begin
            sat_sum = raw_sum[ACC_WIDTH-1:0];
        end else if (raw_sum[ACC_WIDTH]) begin
            sat_sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            sat_sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beats_q    <= '0;
            bias_q     <= '0;
            count      <= '0;
            psum_q     <= '0;
            pipe_valid <= 1'b0;
            acc        <= '0;
            overflow   <= 1'b0;
            result     <= 1'b0;
        end else if (clear) begin
            pipe_valid <= 1'b0;
        end else if (frame_start) begin
            beats_q    <= beats;
            bias_q     <= bias;
            count      <= '0;
            pipe_valid <= 1'b0;
            acc        <= '0;
            overflow   <= 1'b0;
        end else begin
            pipe_valid <= accept;
            if (accept) begin
                psum_q <= lane_sum;
                count  <= count + COUNT_WIDTH'(1);
            end
            if (add_en) begin
                acc <= sat_sum;
                if (sat_hit) begin
                    overflow <= 1'b1;
                end
                if (state == BIAS) begin
                    result <= ~sat_sum[ACC_WIDTH-1];
                end
            end
        end
    end

endmodule

// File: doc/neuron_mac_engine.md
# neuron_mac_engine

Parametrised multi-channel multiply-accumulate neuron for the cat recogniser datapath. Each accepted beat carries CHANNELS unsigned pixels and CHANNELS signed weights. The block multiplies them, sums across channels through a one-stage pipeline and accumulates over a programmable number of beats with saturation. It then adds a signed bias and reports the sign decision (1 = cat) through a result_valid pulse. It sits between the pixel/weight memory readers and the classification control, with a valid/ready input handshake and a start/done frame protocol.

## Interface
- CHANNELS, 3, pixel/weight lanes per beat
- PIXEL_WIDTH, 8, unsigned pixel width per lane
- WEIGHT_WIDTH, 5, signed two's-complement weight width per lane
- BIAS_WIDTH, 16, signed bias width; must be ≤ ACC_WIDTH
- ACC_WIDTH, 40, signed accumulator width; must be ≥ PIXEL_WIDTH+WEIGHT_WIDTH+1+clog2(CHANNELS)
- COUNT_WIDTH, 12, width of beat count

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort; returns to IDLE
- start  in  1  begin a frame; sampled only in IDLE
- beats  in  COUNT_WIDTH  beats per frame; latched on start
- bias  in  BIAS_WIDTH  signed bias; latched on start
- x  in  CHANNELS*PIXEL_WIDTH  pixels; lane i = x[i*PIXEL_WIDTH +: PIXEL_WIDTH]
- w  in  CHANNELS*WEIGHT_WIDTH  weights; lane i = w[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- x_valid  in  1  x/w beat valid
- x_ready  out  1  block accepts a beat
- busy  out  1  state ≠ IDLE
- result_valid  out  1  one-cycle pulse; result and acc_val are final
- result  out  1  1 when the final accumulator is ≥ 0
- acc_val  out  ACC_WIDTH  signed accumulator value
- overflow  out  1  sticky per frame; set when any add saturated

## Operation
- States: IDLE, ACCUM, DRAIN, BIAS, DONE.
- IDLE, start=1, beats≠0: latch beats and bias. Clear acc, beat counter, overflow and pipe_valid. Go to ACCUM.
- IDLE, start=1, beats=0: same latching and clears, then go directly to BIAS.
- ACCUM: x_ready=1. A beat is accepted on an edge where x_valid && x_ready.
- Stage 1, on acceptance: psum_q <= sum over lanes of $signed({1'b0,x_i}) * $signed(w_i), computed at full width (PIXEL_WIDTH+WEIGHT_WIDTH+1+clog2(CHANNELS)). pipe_valid <= 1 on acceptance, otherwise 0.
- Stage 2: when pipe_valid=1, acc <= sat(acc + sext(psum_q)).
- On acceptance of beat number beats (counter = beats−1): go to DRAIN.
- DRAIN: the last psum is absorbed into acc. Go to BIAS.
- BIAS: acc <= sat(acc + sext(bias)). result <= ~sign of the saturated sum. Go to DONE.
- DONE: result_valid=1 for exactly one cycle, then IDLE.
- Saturation: each add is computed at ACC_WIDTH+1 bits and clamped to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. Any clamp sets overflow.
- acc_val = acc at all times. result, acc_val and overflow hold after DONE until the next start.
- start outside IDLE is ignored.
- clear (any state): next state IDLE, pipe_valid <= 0, x_ready low. No result_valid is generated. acc, result and overflow are retained. clear has priority over start.
- Asynchronous reset (low), including mid-frame: all state and outputs go to 0 and the FSM goes to IDLE.

## Timing
- Reset values: x_ready=0, busy=0, result_valid=0, result=0, acc_val=0, overflow=0.
- Start sampled at edge S: busy and x_ready are high after S.
- Last beat accepted at edge E:
  - x_ready is low after E.
  - acc holds the full sum after E+1.
  - Bias is applied at E+2. result_valid is high from E+2 to E+3.
  - busy is low after E+3.
- beats=0, start at S: result_valid is high from S+1 to S+2.
- Gaps in x_valid stall the frame without corrupting the counter. x/w are ignored while x_ready=0.
- Throughput: one beat per cycle. Back-to-back frames need one IDLE cycle for start.

## Test plan
- Defaults, beats=1, lanes x={10,20,30}, w={1,2,3} (lane2..lane0), bias=−141 -> acc_val=−1, result=0, result_valid at E+2. Repeat with bias=−140 -> acc_val=0, result=1.
- beats=4, all x=255, all w=5'b10000 (−16), bias=0 -> acc_val=−48960, result=0, overflow=0.
- beats=3, x_valid pattern 1,0,0,1,0,1, x=1, w=1 -> 3 beats accepted, acc_val=9, x_ready low after third acceptance, exactly one result_valid.
- ACC_WIDTH=16, beats=3, x=255, w=15, bias=0 -> acc_val=32767, overflow=1, result=1. Next frame with beats=1, x=0, bias=0 -> overflow=0, acc_val=0.
- beats=0, bias=−5 -> result_valid one cycle after start, acc_val=−5, result=0.
- Abort mid-frame:
  - clear during beat 2 of 4 -> IDLE next cycle, no result_valid. A new start then runs a correct frame.
  - reset low mid-frame -> all outputs 0 immediately.
  - start pulsed while busy -> ignored.
